// File: rtl/lfsr_scrambler_par_if.sv
// Valid/ready bit-stream bus carrying DW data bits plus a frame-end marker.
`timescale 1ns/1ps
interface lfsr_scrambler_par_if #(
  parameter int DW = 1
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/lfsr_scrambler_par.sv
// Parametrised LFSR scrambler/descrambler: additive, self-sync scramble/descramble or bypass per frame.
// One registered output stage (1-cycle latency); s.ready = !m.valid | m.ready, output holds while stalled.
`timescale 1ns/1ps
module lfsr_scrambler_par #(
  parameter int           L           = 7,
  parameter logic [L-1:0] TAPS        = 7'b1001000,
  parameter logic [L-1:0] SEED        = 7'h7F,
  parameter int           DW          = 1,
  parameter bit           AUTO_RESEED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           cfg_mode,
  input  logic [L-1:0]         cfg_seed,
  input  logic                 seed_load,
  lfsr_scrambler_par_if.slave  s,
  lfsr_scrambler_par_if.master m,
  output logic                 busy
);

  if (L < 2 || L > 32) begin : g_bad_l
    $fatal(1, "lfsr_scrambler_par: L must be in 2..32");
  end
  if (DW < 1 || DW > 32) begin : g_bad_dw
    $fatal(1, "lfsr_scrambler_par: DW must be in 1..32");
  end

  typedef enum logic {IDLE, IN_FRAME} fsm_t;

  fsm_t          r_fsm;
  logic [L-1:0]  r_st;
  logic [1:0]    r_mode;
  logic          r_busy;
  logic          r_m_valid;
  logic [DW-1:0] r_m_data;
  logic          r_m_last;

  logic          w_s_rdy;
  logic          w_acc;
  logic [1:0]    w_mode;
  logic [L-1:0]  w_st_start;
  logic [L-1:0]  w_walk;
  logic [L-1:0]  w_st_next;
  logic          w_fb;
  logic [DW-1:0] w_out;

  assign w_s_rdy    = !r_m_valid || m.ready;
  assign w_acc      = s.valid && w_s_rdy;
  // A frame's first beat (including a single-beat frame) sees cfg_mode live.
  assign w_mode     = (r_fsm == IN_FRAME) ? r_mode : cfg_mode;
  assign w_st_start = seed_load ? cfg_seed : r_st;

  // Walk the register once per bit, bit 0 first in time.
  always_comb begin
    w_walk = w_st_start;
    w_fb   = 1'b0;
    w_out  = '0;
    for (int i = 0; i < DW; i++) begin
      w_fb = ^(w_walk & TAPS);
      case (w_mode)
        2'd0: begin
          w_out[i] = s.data[i] ^ w_fb;
          w_walk   = {w_walk[L-2:0], w_fb};
        end
        2'd1: begin
          w_out[i] = s.data[i] ^ w_fb;
          w_walk   = {w_walk[L-2:0], s.data[i] ^ w_fb};
        end
        2'd2: begin
          w_out[i] = s.data[i] ^ w_fb;
          w_walk   = {w_walk[L-2:0], s.data[i]};
        end
        default: w_out[i] = s.data[i];
      endcase
    end
  end

  assign w_st_next = w_walk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm     <= IDLE;
      r_st      <= SEED;
      r_mode    <= 2'd0;
      r_busy    <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_out;
        r_m_last  <= s.last;
        // Frame end reseed takes priority over any same-cycle seed_load.
        r_st      <= (s.last && AUTO_RESEED) ? SEED : w_st_next;
        case (r_fsm)
          IDLE: begin
            if (!s.last) begin
              r_fsm  <= IN_FRAME;
              r_mode <= cfg_mode;
              r_busy <= 1'b1;
            end
          end
          IN_FRAME: begin
            if (s.last) begin
              r_fsm  <= IDLE;
              r_busy <= 1'b0;
            end
          end
        endcase
      end else begin
        if (m.ready) begin
          r_m_valid <= 1'b0;
        end
        if (seed_load) begin
          r_st <= cfg_seed;
        end
      end
    end
  end

  assign s.ready = w_s_rdy;
  assign m.valid = r_m_valid;
  assign m.data  = r_m_data;
  assign m.last  = r_m_last;
  assign busy    = r_busy;

endmodule

// File: tb/tb_lfsr_scrambler_par.sv
// Directed bench for lfsr_scrambler_par: a DW=1 instance for framing/handshake/seed cases and a DW=8 instance for byte output and sequence period.
`timescale 1ns/1ps
module tb_lfsr_scrambler_par;

  logic       clk;
  logic       rst_n;
  logic [1:0] a_mode, b_mode;
  logic [6:0] a_seed, b_seed;
  logic       a_load, b_load;
  logic       a_busy, b_busy;

  lfsr_scrambler_par_if #(.DW(1)) a_s ();
  lfsr_scrambler_par_if #(.DW(1)) a_m ();
  lfsr_scrambler_par_if #(.DW(8)) b_s ();
  lfsr_scrambler_par_if #(.DW(8)) b_m ();

  lfsr_scrambler_par #(.DW(1)) u_a (
    .clk(clk), .rst_n(rst_n), .cfg_mode(a_mode), .cfg_seed(a_seed),
    .seed_load(a_load), .s(a_s), .m(a_m), .busy(a_busy)
  );

  lfsr_scrambler_par #(.DW(8)) u_b (
    .clk(clk), .rst_n(rst_n), .cfg_mode(b_mode), .cfg_seed(b_seed),
    .seed_load(b_load), .s(b_s), .m(b_m), .busy(b_busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0]  cap;
  logic [63:0]  scr;
  logic [63:0]  dsc;
  logic [63:0]  src;
  logic [143:0] bvec;
  logic [5:0]   bp_d;
  logic [5:0]   bp_exp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends an n-beat frame on the DW=1 instance; load_k/mid_k select a beat for seed_load / cfg_mode change.
  task automatic a_frame(input int n, input logic [63:0] d, input int load_k,
                         input int mid_k, input logic [1:0] mid_mode, output logic [63:0] o);
    o = '0;
    for (int k = 0; k < n; k++) begin
      if (k == mid_k) a_mode = mid_mode;
      a_s.valid = 1'b1;
      a_s.data  = d[k];
      a_s.last  = (k == n - 1);
      a_load    = (k == load_k);
      tick();
      o[k] = a_m.data[0];
    end
    a_s.valid = 1'b0;
    a_s.last  = 1'b0;
    a_load    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_mode = 2'd0; a_seed = 7'h7F; a_load = 1'b0;
    b_mode = 2'd0; b_seed = 7'h7F; b_load = 1'b0;
    a_s.valid = 1'b0; a_s.data = '0; a_s.last = 1'b0; a_m.ready = 1'b1;
    b_s.valid = 1'b0; b_s.data = '0; b_s.last = 1'b0; b_m.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    chk("rst_m_valid", a_m.valid, 0);
    chk("rst_m_data", a_m.data, 0);
    chk("rst_m_last", a_m.last, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_s_ready", a_s.ready, 1);
    chk("rst_b_m_valid", b_m.valid, 0);
    rst_n = 1'b1;
    tick();

    // Byte-wide additive: first byte after reset, and the 127-bit period
    b_s.valid = 1'b1;
    b_s.data  = 8'h00;
    for (int k = 0; k < 18; k++) begin
      b_s.last = (k == 17);
      tick();
      bvec[k*8 +: 8] = b_m.data;
    end
    b_s.valid = 1'b0;
    b_s.last  = 1'b0;
    chk("b_first_byte", bvec[7:0], 8'h70);
    chk("b_first16", bvec[15:0], 16'h4F70);
    chk("b_wrap_bit128", bvec[142:127], 16'h4F70);
    chk("b_busy_end", b_busy, 0);

    // Additive, 9 zero bits, one-cycle latency
    a_mode    = 2'd0;
    a_s.valid = 1'b1;
    a_s.data  = 1'b0;
    chk("lat_pre_valid", a_m.valid, 0);
    for (int k = 0; k < 9; k++) begin
      a_s.last = (k == 8);
      tick();
      cap[k] = a_m.data[0];
      if (k == 0) begin
        chk("lat_valid", a_m.valid, 1);
        chk("busy_in_frame", a_busy, 1);
      end
    end
    a_s.valid = 1'b0;
    a_s.last  = 1'b0;
    chk("add9_seq", cap[8:0], 9'h170);
    chk("add9_m_last", a_m.last, 1);
    chk("add9_busy_end", a_busy, 0);
    tick();
    chk("valid_drop", a_m.valid, 0);

    // Auto-reseed: identical 16-bit frames; mid-frame mode change ignored
    a_mode = 2'd0;
    a_frame(16, 64'h0, -1, -1, 2'd0, cap);
    chk("reseed_frame1", cap[15:0], 16'h4F70);
    a_mode = 2'd0;
    a_frame(16, 64'h0, -1, 1, 2'd3, cap);
    chk("reseed_frame2_modechg", cap[15:0], 16'h4F70);
    a_frame(16, 64'hA5C3, -1, -1, 2'd0, cap);
    chk("bypass_next_frame", cap[15:0], 16'hA5C3);

    // Backpressure: 5-cycle stall with a pending beat
    a_mode = 2'd0;
    bp_d   = 6'b101011;
    bp_exp = 6'b011011;
    a_s.valid = 1'b1;
    a_s.data  = bp_d[0];
    a_s.last  = 1'b0;
    tick();
    chk("bp_beat0", a_m.data, bp_exp[0]);
    a_m.ready = 1'b0;
    a_s.data  = bp_d[1];
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_s_ready", a_s.ready, 0);
      chk("bp_hold_data", a_m.data, bp_exp[0]);
      chk("bp_hold_valid", a_m.valid, 1);
    end
    a_m.ready = 1'b1;
    cap = '0;
    for (int k = 1; k < 6; k++) begin
      a_s.data = bp_d[k];
      a_s.last = (k == 5);
      tick();
      cap[k] = a_m.data[0];
    end
    a_s.valid = 1'b0;
    a_s.last  = 1'b0;
    chk("bp_order", cap[5:1], bp_exp[5:1]);
    chk("bp_m_last", a_m.last, 1);
    tick();
    chk("bp_no_dup", a_m.valid, 0);

    // Self-sync round trip: scramble from SEED, descramble from 0
    src    = 64'hDEAD_BEEF_0123_CAFE;
    a_mode = 2'd1;
    a_frame(64, src, -1, -1, 2'd0, scr);
    a_mode = 2'd2;
    a_seed = 7'h00;
    a_frame(64, scr, 0, -1, 2'd0, dsc);
    chk("rt_bit0", dsc[0], src[0]);
    chk("rt_hi_bits", dsc[63:32], src[63:32]);
    chk("rt_lo_bits_from7", dsc[31:7], src[31:7]);

    // Idle seed_load changes state only
    a_mode = 2'd0;
    a_seed = 7'h08;
    a_load = 1'b1;
    tick();
    a_load = 1'b0;
    chk("idle_load_busy", a_busy, 0);
    chk("idle_load_no_valid", a_m.valid, 0);
    a_frame(4, 64'h0, -1, -1, 2'd0, cap);
    chk("idle_load_seq", cap[3:0], 4'h9);

    // seed_load on the first beat after the state was moved elsewhere
    a_seed = 7'h00;
    a_load = 1'b1;
    tick();
    a_load = 1'b0;
    a_seed = 7'h7F;
    a_frame(9, 64'h0, 0, -1, 2'd0, cap);
    chk("load_first_beat", cap[8:0], 9'h170);

    // Mid-frame resync
    a_seed = 7'h7F;
    a_frame(13, 64'h0, 4, -1, 2'd0, cap);
    chk("mid_resync", cap[12:0], 13'h1700);

    // Asynchronous reset mid-frame
    a_mode    = 2'd0;
    a_s.valid = 1'b1;
    a_s.data  = 1'b1;
    a_s.last  = 1'b0;
    repeat (3) tick();
    a_s.valid = 1'b0;
    chk("pre_rst_busy", a_busy, 1);
    chk("pre_rst_data", a_m.data, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", a_m.valid, 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_data", a_m.data, 0);
    chk("mid_rst_last", a_m.last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    a_frame(9, 64'h0, -1, -1, 2'd0, cap);
    chk("post_rst_seq", cap[8:0], 9'h170);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
